// File: rtl/vga_frame_decoder_if.sv
// VGA sink bus as seen by the frame decoder: pixel-rate strobe, syncs, blanking and colour.
interface vga_frame_decoder_if;
  logic       pix_en;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    output pix_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  pix_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_frame_decoder.sv
// VGA bus monitor: recovers pixel coordinates/colour, checks line/frame timing, tracks lock.
// Optional frame signature (CRC-16-CCITT over valid pixels) enabled by defining VGA_DEC_CRC_EN.
module vga_frame_decoder #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  vga_frame_decoder_if.slave  vga,
  output logic                pix_valid,
  output logic [9:0]          pix_x,
  output logic [8:0]          pix_y,
  output logic [23:0]         pix_rgb,
  output logic                frame_done,
  output logic                locked,
  output logic                h_err,
  output logic                v_err,
  output logic [15:0]         frame_crc
);

  localparam int unsigned HW   = 11;
  localparam int unsigned LW   = 10;
  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 9;
  localparam int unsigned RGBW = 24;

  localparam logic [HW-1:0] H_TOTAL_C  = HW'(H_TOTAL);
  localparam logic [LW-1:0] V_TOTAL_C  = LW'(V_TOTAL);
  localparam logic [XW-1:0] H_ACTIVE_C = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACTIVE_C = YW'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e state_q, state_d;

  // input sample stage, loaded only on pix_en
  logic            tick_q, tick_d;
  logic            hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic            vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic            blank_q, blank_d;
  logic [RGBW-1:0] rgb_q, rgb_d;

  // timing counters
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [XW-1:0]   xcnt_q, xcnt_d;
  logic [YW-1:0]   ycnt_q, ycnt_d;
  logic            meas_q, meas_d;
  logic            fail_q, fail_d;

  // registered outputs
  logic            pix_valid_q, pix_valid_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic [RGBW-1:0] pix_rgb_q, pix_rgb_d;
  logic            frame_done_q, frame_done_d;
  logic            locked_q, locked_d;
  logic            h_err_q, h_err_d;
  logic            v_err_q, v_err_d;

  // per-tick decode
  logic            hs_as, vs_as, act;
  logic [XW-1:0]   x_eff;
  logic [LW-1:0]   lcnt_upd;
  logic [YW-1:0]   ycnt_upd;
  logic            h_fail, v_fail;

  assign hs_as = tick_q && (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
  assign vs_as = tick_q && (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
  assign act   = tick_q && blank_q;

  // HS effects are resolved before VS ones so a shared tick sees updated line/row counts
  always_comb begin
    x_eff    = xcnt_q;
    lcnt_upd = lcnt_q;
    ycnt_upd = ycnt_q;
    h_fail   = 1'b0;
    v_fail   = 1'b0;

    if (act && (xcnt_q != '1)) begin
      x_eff = xcnt_q + XW'(1);
    end

    if (hs_as) begin
      h_fail   = (hcnt_q != H_TOTAL_C) ||
                 ((x_eff != '0) && (x_eff != H_ACTIVE_C));
      lcnt_upd = (lcnt_q == '1) ? lcnt_q : lcnt_q + LW'(1);
      if ((x_eff != '0) && (ycnt_q != '1)) begin
        ycnt_upd = ycnt_q + YW'(1);
      end
    end

    if (vs_as) begin
      v_fail = (lcnt_upd != V_TOTAL_C) || (ycnt_upd != V_ACTIVE_C);
    end
  end

  // sampling, counters, lock FSM next-state and outputs
  always_comb begin
    tick_d       = vga.pix_en;
    hs_d         = hs_q;
    hs_prev_d    = hs_prev_q;
    vs_d         = vs_q;
    vs_prev_d    = vs_prev_q;
    blank_d      = blank_q;
    rgb_d        = rgb_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    xcnt_d       = xcnt_q;
    ycnt_d       = ycnt_q;
    meas_d       = meas_q;
    fail_d       = fail_q;
    state_d      = state_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    h_err_d      = h_err_q;
    v_err_d      = v_err_q;

    if (vga.pix_en) begin
      hs_prev_d = hs_q;
      vs_prev_d = vs_q;
      hs_d      = vga.VGA_HS;
      vs_d      = vga.VGA_VS;
      blank_d   = vga.VGA_BLANK_N;
      rgb_d     = {vga.VGA_R, vga.VGA_G, vga.VGA_B};
    end

    if (tick_q) begin
      if (hs_as) begin
        hcnt_d = HW'(1);
      end else if (hcnt_q != '1) begin
        hcnt_d = hcnt_q + HW'(1);
      end
      xcnt_d = hs_as ? '0 : x_eff;
      lcnt_d = vs_as ? '0 : lcnt_upd;
      ycnt_d = vs_as ? '0 : ycnt_upd;

      if (act && (state_q == ST_LOCKED)) begin
        pix_valid_d = 1'b1;
        pix_x_d     = xcnt_q;
        pix_y_d     = ycnt_q;
        pix_rgb_d   = rgb_q;
      end

      unique case (state_q)
        ST_HUNT: begin
          if (vs_as) begin
            state_d = ST_SYNC;
            meas_d  = 1'b1;
            fail_d  = 1'b0;
            lcnt_d  = '0;
            xcnt_d  = '0;
            ycnt_d  = '0;
          end
        end
        ST_SYNC: begin
          // a measurement only counts when it spans a whole VS-to-VS frame
          if (vs_as) begin
            if (meas_q && !fail_q && !h_fail && !v_fail) begin
              state_d = ST_LOCKED;
            end
            meas_d = 1'b1;
            fail_d = 1'b0;
          end else if (h_fail) begin
            fail_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (h_fail) begin
            h_err_d = 1'b1;
            state_d = ST_SYNC;
            meas_d  = vs_as;
            fail_d  = 1'b0;
          end else if (vs_as) begin
            if (v_fail) begin
              v_err_d = 1'b1;
              state_d = ST_SYNC;
              meas_d  = 1'b1;
              fail_d  = 1'b0;
            end else begin
              frame_done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // lock state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // sync samples reset to the asserted level so no false edge follows reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_q       <= 1'b0;
      hs_q         <= SYNC_POL;
      hs_prev_q    <= SYNC_POL;
      vs_q         <= SYNC_POL;
      vs_prev_q    <= SYNC_POL;
      blank_q      <= 1'b0;
      rgb_q        <= '0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      xcnt_q       <= '0;
      ycnt_q       <= '0;
      meas_q       <= 1'b0;
      fail_q       <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      hs_q         <= hs_d;
      hs_prev_q    <= hs_prev_d;
      vs_q         <= vs_d;
      vs_prev_q    <= vs_prev_d;
      blank_q      <= blank_d;
      rgb_q        <= rgb_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      meas_q       <= meas_d;
      fail_q       <= fail_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
    end
  end

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_q, crc_d, crc_px;
  logic [15:0] frame_crc_q, frame_crc_d;

  function automatic logic [15:0] crc16_pixel(input logic [15:0] c, input logic [RGBW-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = RGBW - 1; i >= 0; i--) begin
      if (r[15] ^ d[i]) begin
        r = {r[14:0], 1'b0} ^ 16'h1021;
      end else begin
        r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  // running signature, re-seeded at every VS and latched on a clean locked frame end
  always_comb begin
    crc_px      = pix_valid_d ? crc16_pixel(crc_q, rgb_q) : crc_q;
    crc_d       = vs_as ? 16'hFFFF : crc_px;
    frame_crc_d = frame_done_d ? crc_px : frame_crc_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = '0;
`endif

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;

endmodule
